// File: rtl/jtag_debug_cmd_queue.sv
// Sysclk-side JTAG debug command queue: strobe sync, capture FIFO, one-hot action decode.
// Optional odd-parity screening of captures is enabled by defining JTAG_DEBUG_CMD_PARITY_EN.
module jtag_debug_cmd_queue #(
  parameter int IR_W        = 2,
  parameter int SR_W        = 38,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACTION_BIT  = 35
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         vs_udr,
  input  logic                         vs_uir,
  input  logic [IR_W-1:0]              ir_in,
  input  logic [SR_W-1:0]              sr,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [IR_W-1:0]              cmd_ir,
  output logic [SR_W-1:0]              cmd_data,
  output logic [(2**IR_W)-1:0]         take_action,
  output logic [(2**IR_W)-1:0]         take_no_action,
  output logic                         ir_update,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow,
  input  logic                         clear_overflow
`ifdef JTAG_DEBUG_CMD_PARITY_EN
  ,
  output logic [7:0]                   parity_err_cnt
`endif
);

  localparam int NV = 2**IR_W;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(SYNC_STAGES+2);
  localparam int EW = IR_W + SR_W;
  localparam logic [AW-1:0] ARM_LOAD = AW'(SYNC_STAGES+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic                   udr_dly;
  logic                   uir_dly;
  logic [AW-1:0]          arm_cnt;

  logic [EW-1:0]          mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;

  logic                   armed;
  logic                   udr_rise;
  logic                   uir_rise;
  logic                   cap_ok;
  logic                   cap_req;
  logic                   accept;
  logic                   full;
  logic                   wr_en;
  logic                   drop;
  logic [PW-1:0]          rd_ptr_nxt;
  logic [CW-1:0]          held_nxt;
  logic [NV-1:0]          head_onehot;

  assign armed    = (arm_cnt == '0);
  assign udr_rise = armed & udr_sync[SYNC_STAGES-1] & ~udr_dly;
  assign uir_rise = armed & uir_sync[SYNC_STAGES-1] & ~uir_dly;

`ifdef JTAG_DEBUG_CMD_PARITY_EN
  // sr MSB carries odd parity over the rest of sr and the IR code
  assign cap_ok = ^{ir_in, sr};
`else
  assign cap_ok = 1'b1;
`endif

  assign cap_req    = udr_rise & cap_ok;
  assign accept     = cmd_valid & cmd_ready;
  assign full       = (count == FULL_CNT);
  assign wr_en      = cap_req & (~full | accept);
  assign drop       = cap_req & full & ~accept;
  assign rd_ptr_nxt = rd_ptr + PW'(accept);
  // Entries that already existed before this edge and survive it; a same-edge
  // write only becomes eligible for the head one cycle later.
  assign held_nxt   = count - CW'(accept);

  assign head_onehot = {{(NV-1){1'b0}}, 1'b1} << cmd_ir;
  assign fifo_count  = count;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {ir_in, sr};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync       <= '0;
      uir_sync       <= '0;
      udr_dly        <= 1'b0;
      uir_dly        <= 1'b0;
      arm_cnt        <= ARM_LOAD;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      cmd_valid      <= 1'b0;
      cmd_ir         <= '0;
      cmd_data       <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      ir_update      <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_dly  <= udr_sync[SYNC_STAGES-1];
      uir_dly  <= uir_sync[SYNC_STAGES-1];
      if (arm_cnt != '0) begin
        arm_cnt <= arm_cnt - AW'(1);
      end

      ir_update <= uir_rise;

      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count + CW'(wr_en) - CW'(accept);

      cmd_valid <= (held_nxt != '0);
      if (held_nxt != '0) begin
        {cmd_ir, cmd_data} <= mem[rd_ptr_nxt];
      end

      take_action    <= '0;
      take_no_action <= '0;
      if (accept) begin
        if (cmd_data[ACTION_BIT]) begin
          take_action <= head_onehot;
        end else begin
          take_no_action <= head_onehot;
        end
      end

      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef JTAG_DEBUG_CMD_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err_cnt <= '0;
    end else if (udr_rise & ~cap_ok & (parity_err_cnt != 8'hFF)) begin
      parity_err_cnt <= parity_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jtag_debug_cmd_queue.sv
// Self-checking bench for jtag_debug_cmd_queue: queue-level reference model plus directed literal checks.
// Also covers the parity build when JTAG_DEBUG_CMD_PARITY_EN is defined.
module tb_jtag_debug_cmd_queue;
  localparam int IR_W  = 2;
  localparam int SR_W  = 38;
  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam int AB    = 35;
  localparam int NV    = 1 << IR_W;
  localparam int CW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vs_udr = 1'b0, vs_uir = 1'b0, cmd_ready = 1'b0, clear_overflow = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [SR_W-1:0] sr = '0;
  logic cmd_valid, ir_update, overflow;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] cmd_data;
  logic [NV-1:0] take_action, take_no_action;
  logic [CW-1:0] fifo_count;
`ifdef JTAG_DEBUG_CMD_PARITY_EN
  logic [7:0] parity_err_cnt;
  int exp_perr;
`endif

  jtag_debug_cmd_queue #(.IR_W(IR_W), .SR_W(SR_W), .DEPTH(DEPTH), .SYNC_STAGES(SS), .ACTION_BIT(AB)) dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .take_action(take_action), .take_no_action(take_no_action), .ir_update(ir_update),
    .fifo_count(fifo_count), .overflow(overflow), .clear_overflow(clear_overflow)
`ifdef JTAG_DEBUG_CMD_PARITY_EN
    , .parity_err_cnt(parity_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [IR_W-1:0] ir; logic [SR_W-1:0] data; int wr; } ent_t;
  ent_t q[$];
  bit udr_s[int];
  bit uir_s[int];
  int k = 0;
  int checks = 0;
  int failures = 0;
  bit exp_ov = 0, exp_iru = 0, was_reset = 0;
  logic [NV-1:0] exp_act = '0, exp_nact = '0;
  logic [SR_W-1:0] obs[$];

  function automatic bit hu(int j); return (j >= 1 && udr_s.exists(j)) ? udr_s[j] : 1'b0; endfunction
  function automatic bit hi(int j); return (j >= 1 && uir_s.exists(j)) ? uir_s[j] : 1'b0; endfunction
  // the head is visible once its entry was written at an earlier edge than the latest one
  function automatic bit mvalid(); return q.size() > 0 && q[0].wr < k; endfunction

  function automatic logic [SR_W-1:0] fixp(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d);
    logic [SR_W-1:0] r;
    r = d;
`ifdef JTAG_DEBUG_CMD_PARITY_EN
    r[SR_W-1] = ~(^{ir, d[SR_W-2:0]});
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("cmd_valid", {63'd0, cmd_valid}, {63'd0, mvalid()});
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("overflow", {63'd0, overflow}, {63'd0, exp_ov});
    chk("take_action", 64'(take_action), 64'(exp_act));
    chk("take_no_action", 64'(take_no_action), 64'(exp_nact));
    chk("ir_update", {63'd0, ir_update}, {63'd0, exp_iru});
    if (mvalid()) begin
      chk("cmd_ir", 64'(cmd_ir), 64'(q[0].ir));
      chk("cmd_data", 64'(cmd_data), 64'(q[0].data));
    end
    if (was_reset) chk("reset_cmd_data", 64'(cmd_data), 64'd0);
`ifdef JTAG_DEBUG_CMD_PARITY_EN
    chk("parity_err_cnt", 64'(parity_err_cnt), 64'(exp_perr));
`endif
  endtask

  // one clock: update the model from current inputs, clock, then check
  task automatic step();
    int n;
    bit rise_d, rise_i, drop, ok;
    n = k + 1;
    was_reset = reset;
    if (reset) begin
      q.delete(); udr_s.delete(); uir_s.delete();
      exp_ov = 0; exp_iru = 0; exp_act = '0; exp_nact = '0; k = 0;
`ifdef JTAG_DEBUG_CMD_PARITY_EN
      exp_perr = 0;
`endif
    end else begin
      if (cmd_valid && cmd_ready) obs.push_back(cmd_data);
      udr_s[n] = vs_udr;
      uir_s[n] = vs_uir;
      exp_act = '0; exp_nact = '0;
      if (mvalid() && cmd_ready) begin
        if (q[0].data[AB]) exp_act[q[0].ir] = 1'b1;
        else exp_nact[q[0].ir] = 1'b1;
        void'(q.pop_front());
      end
      rise_d = (n >= SS + 2) && hu(n - SS) && !hu(n - SS - 1);
      rise_i = (n >= SS + 2) && hi(n - SS) && !hi(n - SS - 1);
      ok = 1'b1;
`ifdef JTAG_DEBUG_CMD_PARITY_EN
      ok = ^{ir_in, sr};
      if (rise_d && !ok && exp_perr < 255) exp_perr++;
`endif
      drop = 0;
      if (rise_d && ok) begin
        if (q.size() < DEPTH) q.push_back('{ir_in, sr, n});
        else drop = 1;
      end
      if (drop) exp_ov = 1;
      else if (clear_overflow) exp_ov = 0;
      exp_iru = rise_i;
      k = n;
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic pulse(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d);
    ir_in = ir; sr = d; vs_udr = 1'b1; step();
    vs_udr = 1'b0; repeat (4) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  logic vv[1:6];
  logic [SR_W-1:0] dd[1:6];
  logic [NV-1:0] na[1:6], ac[1:6];
  int rdy_pct;

  initial begin
    // strobe already high at reset release must not produce a command
    vs_udr = 1'b1;
    do_reset();
    repeat (20) step();
    chk("hold_high_count", 64'(fifo_count), 64'd0);
    chk("hold_high_valid", {63'd0, cmd_valid}, 64'd0);
    vs_udr = 1'b0; repeat (3) step();
    vs_udr = 1'b1; repeat (3) step();
    vs_udr = 1'b0; repeat (3) step();
    chk("rearm_count", 64'(fifo_count), 64'd1);
    cmd_ready = 1'b1; repeat (3) step(); cmd_ready = 1'b0;
    chk("rearm_drained", 64'(fifo_count), 64'd0);

    // latency and no_action decode
    ir_in = 2'b01; sr = fixp(2'b01, 38'h20_0000_0ABC); cmd_ready = 1'b1;
    vs_udr = 1'b1; step(); vs_udr = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(); vv[i] = cmd_valid; dd[i] = cmd_data; na[i] = take_no_action; ac[i] = take_action;
    end
    chk("lat_valid_e2", {63'd0, vv[2]}, 64'd0);
    chk("lat_valid_e3", {63'd0, vv[3]}, 64'd1);
    chk("lat_data", 64'(dd[3]), 64'(fixp(2'b01, 38'h20_0000_0ABC)));
    chk("no_action_pulse", 64'(na[4]), 64'h2);
    chk("no_action_act0", 64'(ac[4]), 64'h0);
    chk("no_action_one_cycle", 64'(na[5]), 64'h0);

    // action decode
    ir_in = 2'b11; sr = fixp(2'b11, 38'h28_0000_0ABC);
    vs_udr = 1'b1; step(); vs_udr = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(); na[i] = take_no_action; ac[i] = take_action;
    end
    chk("action_pulse", 64'(ac[4]), 64'h8);
    chk("action_nact0", 64'(na[4]), 64'h0);
    chk("action_one_cycle", 64'(ac[5]), 64'h0);
    cmd_ready = 1'b0;

    // overflow on a fifth capture, then ordered drain
    for (int d = 1; d <= 5; d++) pulse(2'b00, fixp(2'b00, SR_W'(d)));
    chk("ovf_count", 64'(fifo_count), 64'd4);
    chk("ovf_flag", {63'd0, overflow}, 64'd1);
    obs.delete();
    cmd_ready = 1'b1; repeat (8) step(); cmd_ready = 1'b0;
    chk("drain_n", 64'(obs.size()), 64'd4);
    for (int i = 0; i < obs.size() && i < 4; i++) chk("drain_order", 64'(obs[i]), 64'(fixp(2'b00, SR_W'(i + 1))));
    chk("drain_count", 64'(fifo_count), 64'd0);

    // full with a same-cycle accept: write succeeds, count unchanged
    for (int d = 1; d <= 4; d++) pulse(2'b00, fixp(2'b00, SR_W'(d)));
    ir_in = 2'b00; sr = fixp(2'b00, SR_W'(6));
    vs_udr = 1'b1; step(); vs_udr = 1'b0; step();
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0; step();
    chk("full_accept_count", 64'(fifo_count), 64'd4);
    chk("full_accept_ovf", {63'd0, overflow}, 64'd1);
    obs.delete();
    cmd_ready = 1'b1; repeat (8) step(); cmd_ready = 1'b0;
    chk("full_accept_n", 64'(obs.size()), 64'd4);
    if (obs.size() == 4) chk("full_accept_last", 64'(obs[3]), 64'(fixp(2'b00, SR_W'(6))));

    // clear alone clears; clear together with a drop keeps overflow set
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    chk("ovf_cleared", {63'd0, overflow}, 64'd0);
    for (int d = 1; d <= 4; d++) pulse(2'b00, fixp(2'b00, SR_W'(d)));
    ir_in = 2'b00; sr = fixp(2'b00, SR_W'(5));
    vs_udr = 1'b1; step(); vs_udr = 1'b0; step();
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0; step();
    chk("drop_beats_clear", {63'd0, overflow}, 64'd1);
    cmd_ready = 1'b1; repeat (6) step(); cmd_ready = 1'b0;

`ifdef JTAG_DEBUG_CMD_PARITY_EN
    do_reset(); repeat (4) step();
    for (int d = 1; d <= 3; d++) begin
      sr = fixp(2'b00, SR_W'(d));
      sr[SR_W-1] = ~sr[SR_W-1];
      pulse(2'b00, sr);
    end
    pulse(2'b00, fixp(2'b00, SR_W'(9)));
    chk("parity_err_3", 64'(parity_err_cnt), 64'd3);
    chk("parity_one_entry", 64'(fifo_count), 64'd1);
`endif

    // randomized traffic with occasional mid-operation reset
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rdy_pct = ((c / 300) % 3 == 0) ? 15 : (((c / 300) % 3 == 1) ? 85 : 50);
      if ($urandom_range(0, 2) == 0) vs_udr = ~vs_udr;
      if ($urandom_range(0, 3) == 0) vs_uir = ~vs_uir;
      if (!vs_udr && $urandom_range(0, 1) == 1) begin
        ir_in = IR_W'($urandom());
        sr = SR_W'({$urandom(), $urandom()});
      end
      cmd_ready = ($urandom_range(0, 99) < rdy_pct);
      clear_overflow = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
